bcd_time_counter: RTL and testbench

Parametrised wrap-around time counter for the clock datapath. It generalises the seconds/minutes counter to any range and digit count, and to a non-zero minimum such as 1..12. It adds synchronous BCD preset for time setting, an optional decrement path, and directly registered BCD digit outputs for the seven-segment drivers. Instances chain by feeding one stage's `rollover`/`borrow` into the next stage's `inc_tick`/`dec_tick`.

---
 rtl/bcd_time_counter.sv | 186 ++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   Wrap-around time counter over MIN_COUNT..MAX_COUNT-1 with a binary count and a
//   registered BCD image kept in step by per-digit carry/borrow (no divider).
//   Synchronous BCD preset with range/nibble validation. Stages chain by feeding
//   rollover/borrow into the next stage's inc_tick/dec_tick.
//
//   Optional feature: define BCD_TIME_COUNTER_DOWN_EN to add the decrement path
//   (dec_tick input, borrow output). Undefined: increment/load only.
//
// Ports
//   clk       clock
//   rst       synchronous active-low reset
//   inc_tick  single-cycle increment request
//   dec_tick  single-cycle decrement request (BCD_TIME_COUNTER_DOWN_EN only)
//   load      synchronous preset strobe
//   load_bcd  preset value in BCD, digit 0 in [3:0]
//   count     binary count
//   digits    registered BCD image of count
//   rollover  combinational carry to the next stage
//   borrow    combinational borrow to the next stage (BCD_TIME_COUNTER_DOWN_EN only)
//   load_err  registered one-cycle pulse for a rejected preset
module bcd_time_counter #(
  parameter int unsigned MIN_COUNT = 0,
  parameter int unsigned MAX_COUNT = 60,
  parameter int unsigned DIGITS    = 2,
  localparam int unsigned CW = $clog2(MAX_COUNT),
  localparam int unsigned BW = 4 * DIGITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_tick,
`ifdef BCD_TIME_COUNTER_DOWN_EN
  input  logic          dec_tick,
  output logic          borrow,
`endif
  input  logic          load,
  input  logic [BW-1:0] load_bcd,
  output logic [CW-1:0] count,
  output logic [BW-1:0] digits,
  output logic          rollover,
  output logic          load_err
);

  // Wide enough for any 4-digit BCD value (9999).
  localparam int unsigned LW = 14;

  // Elaboration-time only; used for the reset and wrap constants.
  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Ripple +1 across BCD digits; a digit at 9 wraps to 0 and carries.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    logic          carry;
    r     = d;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (d[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [BW-1:0] MinBcd = to_bcd(MIN_COUNT);
  localparam logic [CW-1:0] MinVal = CW'(MIN_COUNT);
  localparam logic [CW-1:0] MaxVal = CW'(MAX_COUNT - 1);

  logic          dec_en;
  logic          inc_go;
  logic          at_max;
  logic          nib_ok;
  logic          load_ok;
  logic [LW-1:0] load_val;
  logic [CW:0]   count_inc;
  logic [CW-1:0] count_d;
  logic [BW-1:0] digits_d;

`ifdef BCD_TIME_COUNTER_DOWN_EN
  localparam logic [BW-1:0] MaxBcd = to_bcd(MAX_COUNT - 1);

  // Ripple -1 across BCD digits; a digit at 0 wraps to 9 and borrows.
  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    logic          brw;
    r   = d;
    brw = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (brw) begin
        if (d[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = d[4*i +: 4] - 4'd1;
          brw         = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic        dec_go;
  logic        at_min;
  logic [CW:0] count_dec;

  assign dec_en    = dec_tick;
  assign dec_go    = dec_tick & ~inc_tick & ~load;
  assign at_min    = (count == MinVal);
  assign count_dec = {1'b0, count} - (CW+1)'(1);
  assign borrow    = dec_go & rst & at_min;
`else
  assign dec_en = 1'b0;
`endif

  assign inc_go    = inc_tick & ~dec_en & ~load;
  assign at_max    = (count == MaxVal);
  assign count_inc = {1'b0, count} + (CW+1)'(1);
  assign rollover  = inc_go & rst & at_max;

  // Preset decode: every nibble must be a decimal digit and the value in range.
  always_comb begin
    load_val = '0;
    nib_ok   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib_ok   = nib_ok & (load_bcd[4*i +: 4] <= 4'd9);
      load_val = (load_val * LW'(10)) + LW'(load_bcd[4*i +: 4]);
    end
    load_ok = nib_ok && (load_val >= LW'(MIN_COUNT)) && (load_val <= LW'(MAX_COUNT - 1));
  end

  always_comb begin
    count_d  = count;
    digits_d = digits;
    if (load) begin
      if (load_ok) begin
        count_d  = CW'(load_val);
        digits_d = load_bcd;
      end
    end else if (inc_go) begin
      if (at_max) begin
        count_d  = MinVal;
        digits_d = MinBcd;
      end else begin
        count_d  = CW'(count_inc);
        digits_d = bcd_inc(digits);
      end
    end
`ifdef BCD_TIME_COUNTER_DOWN_EN
    else if (dec_go) begin
      if (at_min) begin
        count_d  = MaxVal;
        digits_d = MaxBcd;
      end else begin
        count_d  = CW'(count_dec);
        digits_d = bcd_dec(digits);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= MinVal;
      digits   <= MinBcd;
      load_err <= 1'b0;
    end else begin
      count    <= count_d;
      digits   <= digits_d;
      load_err <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: seconds->minutes chain (0..59) plus a
// 12-hour stage (1..12). A reference model predicts each edge; expectations are
// queued when stimulus is applied and compared after the edge.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_inc = 1'b0, sec_dec = 1'b0, sec_load = 1'b0;
  logic [7:0] sec_bcd = 8'h00;
  logic       min_load = 1'b0;
  logic [7:0] min_bcd = 8'h00;
  logic       hr_inc = 1'b0, hr_load = 1'b0;
  logic [7:0] hr_bcd = 8'h00;

  logic [5:0] sec_count, min_count;
  logic [3:0] hr_count;
  logic [7:0] sec_digits, min_digits, hr_digits;
  logic       sec_roll, min_roll, hr_roll;
  logic       sec_err, min_err, hr_err;
`ifdef BCD_TIME_COUNTER_DOWN_EN
  logic       sec_borrow, min_borrow, hr_borrow;
`endif

  int errors = 0;
  int checks = 0;
  int m_sec = 0, m_min = 0, m_hr = 1;

  typedef struct {
    int which;
    int cnt;
    bit err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_time_counter u_sec (
    .clk(clk), .rst(rst), .inc_tick(sec_inc),
`ifdef BCD_TIME_COUNTER_DOWN_EN
    .dec_tick(sec_dec), .borrow(sec_borrow),
`endif
    .load(sec_load), .load_bcd(sec_bcd), .count(sec_count), .digits(sec_digits),
    .rollover(sec_roll), .load_err(sec_err)
  );

  bcd_time_counter u_min (
    .clk(clk), .rst(rst), .inc_tick(sec_roll),
`ifdef BCD_TIME_COUNTER_DOWN_EN
    .dec_tick(1'b0), .borrow(min_borrow),
`endif
    .load(min_load), .load_bcd(min_bcd), .count(min_count), .digits(min_digits),
    .rollover(min_roll), .load_err(min_err)
  );

  bcd_time_counter #(.MIN_COUNT(1), .MAX_COUNT(13), .DIGITS(2)) u_hr (
    .clk(clk), .rst(rst), .inc_tick(hr_inc),
`ifdef BCD_TIME_COUNTER_DOWN_EN
    .dec_tick(1'b0), .borrow(hr_borrow),
`endif
    .load(hr_load), .load_bcd(hr_bcd), .count(hr_count), .digits(hr_digits),
    .rollover(hr_roll), .load_err(hr_err)
  );

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic void model(input int cur, input int mn, input int mx, input bit r,
                                input bit inc, input bit dec, input bit ld,
                                input logic [7:0] bcd, output int nxt, output bit err,
                                output bit roll, output bit brw);
    int v;
    nxt  = cur;
    err  = 1'b0;
    roll = 1'b0;
    brw  = 1'b0;
    v    = int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
    if (!r) begin
      nxt = mn;
    end else if (ld) begin
      if (bcd[7:4] <= 4'd9 && bcd[3:0] <= 4'd9 && v >= mn && v <= mx - 1) nxt = v;
      else err = 1'b1;
    end else if (inc && !dec) begin
      roll = (cur == mx - 1);
      nxt  = roll ? mn : cur + 1;
    end else if (dec && !inc) begin
      brw = (cur == mn);
      nxt = brw ? mx - 1 : cur - 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One clock: check combinational outputs, queue predictions, clock, compare.
  task automatic step();
    int   n_s, n_m, n_h;
    bit   e_s, e_m, e_h, r_s, r_m, r_h, b_s, b_m, b_h;
    exp_t e;
    #1;
    model(m_sec, 0, 60, rst, sec_inc, sec_dec, sec_load, sec_bcd, n_s, e_s, r_s, b_s);
    model(m_min, 0, 60, rst, r_s, 1'b0, min_load, min_bcd, n_m, e_m, r_m, b_m);
    model(m_hr, 1, 13, rst, hr_inc, 1'b0, hr_load, hr_bcd, n_h, e_h, r_h, b_h);
    chk("sec_rollover", 32'(sec_roll), 32'(r_s));
    chk("min_rollover", 32'(min_roll), 32'(r_m));
    chk("hr_rollover", 32'(hr_roll), 32'(r_h));
`ifdef BCD_TIME_COUNTER_DOWN_EN
    chk("sec_borrow", 32'(sec_borrow), 32'(b_s));
    chk("min_borrow", 32'(min_borrow), 32'(b_m));
    chk("hr_borrow", 32'(hr_borrow), 32'(b_h));
`endif
    sb.push_back('{which: 0, cnt: n_s, err: e_s});
    sb.push_back('{which: 1, cnt: n_m, err: e_m});
    sb.push_back('{which: 2, cnt: n_h, err: e_h});
    m_sec = n_s;
    m_min = n_m;
    m_hr  = n_h;
    @(posedge clk);
    #1;
    sec_inc  = 1'b0;
    sec_dec  = 1'b0;
    sec_load = 1'b0;
    min_load = 1'b0;
    hr_inc   = 1'b0;
    hr_load  = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.which)
        0: begin
          chk("sec_count", 32'(sec_count), 32'(e.cnt));
          chk("sec_digits", 32'(sec_digits), 32'(bcd2(e.cnt)));
          chk("sec_load_err", 32'(sec_err), 32'(e.err));
        end
        1: begin
          chk("min_count", 32'(min_count), 32'(e.cnt));
          chk("min_digits", 32'(min_digits), 32'(bcd2(e.cnt)));
          chk("min_load_err", 32'(min_err), 32'(e.err));
        end
        default: begin
          chk("hr_count", 32'(hr_count), 32'(e.cnt));
          chk("hr_digits", 32'(hr_digits), 32'(bcd2(e.cnt)));
          chk("hr_load_err", 32'(hr_err), 32'(e.err));
        end
      endcase
    end
  endtask

  initial begin
    // Reset, including a tick and a bad load that must both be ignored.
    rst = 1'b0;
    step();
    sec_inc = 1'b1; sec_load = 1'b1; sec_bcd = 8'h6A;
    step();
    rst = 1'b1;

    // 60 seconds ticks: 0..59 then wrap; hours tick 12 times (1..12 then wrap).
    for (int i = 0; i < 60; i++) begin
      sec_inc = 1'b1;
      if (i < 12) hr_inc = 1'b1;
      step();
    end

    // Preset with a tick in the same cycle, then invalid presets.
    sec_load = 1'b1; sec_bcd = 8'h45; sec_inc = 1'b1;
    step();
    sec_load = 1'b1; sec_bcd = 8'h6A;
    step();
    step();
    sec_load = 1'b1; sec_bcd = 8'h60;
    step();
    hr_load = 1'b1; hr_bcd = 8'h13;
    step();
    hr_load = 1'b1; hr_bcd = 8'h00;
    step();
    hr_load = 1'b1; hr_bcd = 8'h12; hr_inc = 1'b1;
    step();
    hr_inc = 1'b1;
    step();

`ifdef BCD_TIME_COUNTER_DOWN_EN
    // Decrement wrap, digit borrow, and simultaneous inc/dec.
    sec_load = 1'b1; sec_bcd = 8'h00;
    step();
    sec_dec = 1'b1;
    step();
    sec_inc = 1'b1; sec_dec = 1'b1;
    step();
    sec_load = 1'b1; sec_bcd = 8'h10;
    step();
    sec_dec = 1'b1;
    step();
    sec_dec = 1'b1;
    step();
`endif

    // Chain 59:59 -> 00:00 on one edge with minutes rollover.
    sec_load = 1'b1; sec_bcd = 8'h59; min_load = 1'b1; min_bcd = 8'h59;
    step();
    sec_inc = 1'b1;
    step();

    // Reset in the middle of a wrapping tick and a bad load.
    sec_load = 1'b1; sec_bcd = 8'h59;
    step();
    rst = 1'b0; sec_inc = 1'b1; hr_load = 1'b1; hr_bcd = 8'hA1;
    step();
    rst = 1'b1;

    // Mixed traffic.
    for (int i = 0; i < 40; i++) begin
      sec_inc = 1'($urandom_range(0, 1));
      hr_inc  = 1'($urandom_range(0, 1));
`ifdef BCD_TIME_COUNTER_DOWN_EN
      sec_dec = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 5) == 0) begin
        sec_load = 1'b1; sec_bcd = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 5) == 0) begin
        hr_load = 1'b1; hr_bcd = 8'($urandom_range(0, 31));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
